mem_arbiter: RTL and testbench

- Shares one unified single-port memory between the CPU instruction-fetch port and the data load/store port.
- Replaces the two private memory instances once instruction and data storage are merged.
- Accepts one request at a time, round-robin on conflict, and drives a valid/ready memory interface.
- Routes each response back to its owner, with a response timeout for error containment.

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// data load/store. One transaction in flight, round-robin on conflict, and a
// response timeout so a silent memory cannot hang either requester.
module mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    // data load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    // unified memory port
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    state_t            r_state,      w_state;
    owner_t            r_owner,      w_owner;
    owner_t            r_last_grant, w_last_grant;
    mem_req_t          r_req,        w_req;
    logic [CNT_W-1:0]  r_cnt,        w_cnt;
    logic              r_mem_valid,  w_mem_valid;
    logic              r_i_gnt,      w_i_gnt;
    logic              r_d_gnt,      w_d_gnt;
    logic              r_i_rvalid,   w_i_rvalid;
    logic              r_d_rvalid,   w_d_rvalid;
    logic              r_i_err,      w_i_err;
    logic              r_d_err,      w_d_err;
    logic [DATA_W-1:0] r_i_rdata,    w_i_rdata;
    logic [DATA_W-1:0] r_d_rdata,    w_d_rdata;

    logic              w_pick_d;
    logic              w_done;
    logic              w_done_err;
    logic [DATA_W-1:0] w_done_data;

    // Next-state, arbitration and response routing.
    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_grant = r_last_grant;
        w_req        = r_req;
        w_cnt        = r_cnt;
        w_mem_valid  = r_mem_valid;
        w_i_gnt      = 1'b0;
        w_d_gnt      = 1'b0;
        w_i_rvalid   = 1'b0;
        w_d_rvalid   = 1'b0;
        w_i_err      = 1'b0;
        w_d_err      = 1'b0;
        w_i_rdata    = r_i_rdata;
        w_d_rdata    = r_d_rdata;
        w_pick_d     = 1'b0;
        w_done       = 1'b0;
        w_done_err   = 1'b0;
        w_done_data  = '0;

        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // On conflict the port that did not win last time goes first.
                    w_pick_d = d_req && (!i_req || (r_last_grant == OWN_I));
                    if (w_pick_d) begin
                        w_owner = OWN_D;
                        w_req   = '{we: d_we, addr: d_addr, wdata: d_wdata};
                        w_d_gnt = 1'b1;
                    end else begin
                        w_owner = OWN_I;
                        w_req   = '{we: 1'b0, addr: i_addr, wdata: '0};
                        w_i_gnt = 1'b1;
                    end
                    w_last_grant = w_owner;
                    w_mem_valid  = 1'b1;
                    w_state      = S_REQ;
                end
            end

            S_REQ: begin
                if (r_mem_valid && mem_ready) begin
                    w_mem_valid = 1'b0;
                    w_cnt       = '0;
                    w_state     = S_WAIT;
                end
            end

            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_done      = 1'b1;
                    w_done_data = r_req.we ? '0 : mem_rdata;
                end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state     = S_IDLE;
                w_mem_valid = 1'b0;
            end
        endcase

        // Completion goes only to the port that owns the transaction.
        if (w_done) begin
            if (r_owner == OWN_D) begin
                w_d_rvalid = 1'b1;
                w_d_err    = w_done_err;
                w_d_rdata  = w_done_data;
            end else begin
                w_i_rvalid = 1'b1;
                w_i_err    = w_done_err;
                w_i_rdata  = w_done_data;
            end
            w_state = S_IDLE;
        end
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_I;
            r_last_grant <= OWN_I;
            r_req        <= '0;
            r_cnt        <= '0;
            r_mem_valid  <= 1'b0;
            r_i_gnt      <= 1'b0;
            r_d_gnt      <= 1'b0;
            r_i_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_i_err      <= 1'b0;
            r_d_err      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_grant <= w_last_grant;
            r_req        <= w_req;
            r_cnt        <= w_cnt;
            r_mem_valid  <= w_mem_valid;
            r_i_gnt      <= w_i_gnt;
            r_d_gnt      <= w_d_gnt;
            r_i_rvalid   <= w_i_rvalid;
            r_d_rvalid   <= w_d_rvalid;
            r_i_err      <= w_i_err;
            r_d_err      <= w_d_err;
            r_i_rdata    <= w_i_rdata;
            r_d_rdata    <= w_d_rdata;
        end
    end

    assign i_gnt     = r_i_gnt;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_req.we;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scenario tasks, a behavioural memory and a response
// scoreboard of expected {port, data, err} triples.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we  = 1'b0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_valid, mem_we;
    logic          mem_ready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic resp_en  = 1'b1;
    logic late_req = 1'b0;
    int   hs_count  = 0;
    int   both_cnt  = 0;
    int   gnt_cnt   = 0;
    int   d_act_cnt = 0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit            port;   // 0 = I, 1 = D
        logic [DW-1:0] data;
        bit            err;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory: responds one cycle after a handshake; store acks carry junk data.
    always @(posedge clk) begin
        if (mem_valid && mem_ready) hs_count <= hs_count + 1;
        mem_resp_valid <= (mem_valid && mem_ready && resp_en) || late_req;
        mem_rdata      <= (mem_valid && mem_ready) ? (mem_we ? 32'hFFFF_FFFF : model_data(mem_addr))
                                                   : 32'hBAD0_BAD0;
    end

    // Activity counters read by the scenarios.
    always @(negedge clk) begin
        if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid) || (i_err && d_err)) both_cnt++;
        if (i_gnt || d_gnt) gnt_cnt++;
        if (d_gnt || d_rvalid || d_err) d_act_cnt++;
    end

    task automatic get_resp(input int budget, output int cyc, output logic [1:0] vld,
                            output logic [DW-1:0] data, output logic err);
        bit seen;
        seen = 0; cyc = 0; vld = '0; data = '0; err = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (i_rvalid || d_rvalid) begin
                seen = 1;
                vld  = {d_rvalid, i_rvalid};
                data = d_rvalid ? d_rdata : i_rdata;
                err  = d_rvalid ? d_err : i_err;
            end
        end
    endtask

    task automatic wait_gnt(input int budget, output logic [1:0] g);
        int c;
        g = '0; c = 0;
        while (g == 2'b00 && c < budget) begin
            @(negedge clk);
            c++;
            g = {d_gnt, i_gnt};
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_valid, mem_we} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_valid, mem_we});
        end
        checks++;
        if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", i_rdata, d_rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_valid, i_gnt, d_gnt} !== 3'b000) begin
            failures++;
            $display("FAIL idle_no_req got=%b exp=000", {mem_valid, i_gnt, d_gnt});
        end
    endtask

    task automatic test_single_fetch();
        int cyc; logic [1:0] vld; logic [DW-1:0] data; logic err; exp_t e; int d0;
        d0 = d_act_cnt;
        i_req = 1'b1; i_addr = 32'h10;
        sb.push_back('{port: 1'b0, data: 32'h0050_0093, err: 1'b0});
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, mem_valid, mem_we} !== 4'b1010) begin
            failures++;
            $display("FAIL fetch_gnt got=%b exp=1010", {i_gnt, d_gnt, mem_valid, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL fetch_addr got=%h exp=00000010", mem_addr);
        end
        i_req = 1'b0;
        get_resp(8, cyc, vld, data, err);
        e = sb.pop_front();
        checks++;
        if (vld !== (e.port ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL fetch_owner got=%b exp=01", vld);
        end
        checks++;
        if (data !== e.data || err !== e.err) begin
            failures++; $display("FAIL fetch_data got=%h/%b exp=%h/%b", data, err, e.data, e.err);
        end
        checks++;
        if (cyc != 2) begin
            failures++; $display("FAIL fetch_latency got=%0d exp=2", cyc);
        end
        @(negedge clk);
        checks++;
        if (d_act_cnt != d0 || d_rdata !== 32'h0) begin
            failures++; $display("FAIL fetch_d_quiet got=%0d/%h exp=0/0", d_act_cnt - d0, d_rdata);
        end
    endtask

    task automatic test_store();
        int cyc; logic [1:0] vld; logic [DW-1:0] data; logic err; exp_t e;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        sb.push_back('{port: 1'b1, data: 32'h0, err: 1'b0});
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, mem_valid, mem_we} !== 4'b0111) begin
            failures++; $display("FAIL store_gnt got=%b exp=0111", {i_gnt, d_gnt, mem_valid, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL store_bus got=%h/%h exp=00000200/deadbeef", mem_addr, mem_wdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        get_resp(8, cyc, vld, data, err);
        e = sb.pop_front();
        checks++;
        if (vld !== (e.port ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL store_owner got=%b exp=10", vld);
        end
        checks++;
        if (data !== e.data || err !== e.err) begin
            failures++; $display("FAIL store_ack got=%h/%b exp=%h/%b", data, err, e.data, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int cyc; logic [1:0] vld; logic [DW-1:0] data; logic err; logic [1:0] g; exp_t e;
        bit order [4];
        order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b1; order[3] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i_addr = 32'h100; d_addr = 32'h300; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 4; t++)
            sb.push_back('{port: order[t], data: model_data(order[t] ? 32'h300 : 32'h100), err: 1'b0});
        for (int t = 0; t < 4; t++) begin
            wait_gnt(6, g);
            checks++;
            if (g !== (order[t] ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL rr_grant_%0d got=%b exp=%b", t, g, order[t] ? 2'b10 : 2'b01);
            end
            if (t == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            get_resp(8, cyc, vld, data, err);
            e = sb.pop_front();
            checks++;
            if (vld !== (e.port ? 2'b10 : 2'b01) || data !== e.data) begin
                failures++;
                $display("FAIL rr_resp_%0d got=%b/%h exp=%b/%h", t, vld, data,
                         e.port ? 2'b10 : 2'b01, e.data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc; logic [1:0] vld; logic [DW-1:0] data; logic err; exp_t e;
        resp_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        sb.push_back('{port: 1'b1, data: 32'h0, err: 1'b1});
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++; $display("FAIL to_gnt got=%b exp=1", d_gnt);
        end
        d_req = 1'b0;
        get_resp(12, cyc, vld, data, err);
        e = sb.pop_front();
        checks++;
        if (cyc != 1 + TO) begin
            failures++; $display("FAIL to_latency got=%0d exp=%0d", cyc, 1 + TO);
        end
        checks++;
        if (vld !== 2'b10 || data !== e.data || err !== e.err) begin
            failures++; $display("FAIL to_resp got=%b/%h/%b exp=10/%h/%b", vld, data, err, e.data, e.err);
        end
        resp_en  = 1'b1;
        late_req = 1'b1;
        @(negedge clk);
        late_req = 1'b0;
        get_resp(6, cyc, vld, data, err);
        checks++;
        if (vld !== 2'b00) begin
            failures++; $display("FAIL to_late_resp got=%b exp=00", vld);
        end
    endtask

    task automatic test_backpressure();
        int cyc; logic [1:0] vld; logic [DW-1:0] data; logic err; exp_t e;
        int hs0, g0; bit stable;
        hs0 = hs_count; g0 = gnt_cnt; stable = 1;
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h208; d_wdata = 32'h1234_5678;
        sb.push_back('{port: 1'b1, data: 32'h0, err: 1'b0});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                d_req = 1'b0; d_we = 1'b0;
            end
            if (!(mem_valid === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h208 &&
                  mem_wdata === 32'h1234_5678)) stable = 0;
        end
        mem_ready = 1'b1;
        checks++;
        if (!stable) begin
            failures++; $display("FAIL bp_stable got=%b/%h/%h exp=1/00000208/12345678",
                                 mem_valid, mem_addr, mem_wdata);
        end
        get_resp(8, cyc, vld, data, err);
        e = sb.pop_front();
        checks++;
        if (vld !== 2'b10 || data !== e.data || err !== e.err) begin
            failures++; $display("FAIL bp_resp got=%b/%h/%b exp=10/%h/%b", vld, data, err, e.data, e.err);
        end
        @(negedge clk);
        checks++;
        if (hs_count - hs0 != 1) begin
            failures++; $display("FAIL bp_handshakes got=%0d exp=1", hs_count - hs0);
        end
        checks++;
        if (gnt_cnt - g0 != 1) begin
            failures++; $display("FAIL bp_gnt_pulses got=%0d exp=1", gnt_cnt - g0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int cyc; logic [1:0] vld; logic [DW-1:0] data; logic err; exp_t e;
        resp_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h80;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            failures++; $display("FAIL rst_wait_gnt got=%b exp=1", i_gnt);
        end
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_valid, mem_we} !== 8'h00 ||
            {i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            failures++; $display("FAIL rst_wait_outputs got=%b/%h exp=0/0",
                                 {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_valid, mem_we},
                                 {i_rdata, d_rdata, mem_addr, mem_wdata});
        end
        rst_n = 1'b1;
        get_resp(8, cyc, vld, data, err);
        checks++;
        if (vld !== 2'b00) begin
            failures++; $display("FAIL rst_wait_dropped got=%b exp=00", vld);
        end
        resp_en = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        sb.push_back('{port: 1'b0, data: 32'h0050_0093, err: 1'b0});
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            failures++; $display("FAIL rst_wait_regnt got=%b exp=1", i_gnt);
        end
        i_req = 1'b0;
        get_resp(8, cyc, vld, data, err);
        e = sb.pop_front();
        checks++;
        if (vld !== 2'b01 || data !== e.data || err !== e.err) begin
            failures++; $display("FAIL rst_wait_resp got=%b/%h/%b exp=01/%h/%b", vld, data, err, e.data, e.err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        checks++;
        if (both_cnt != 0) begin
            failures++; $display("FAIL port_exclusive got=%0d exp=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
